// File: rtl/trax_pkg.sv
// Shared Trax definitions: tile codes, edge colours, sides, checker FSM states and
// the edge-colour lookup used by the placement checker.
package trax_pkg;

   localparam logic [2:0] EMPTY  = 3'd0;
   localparam logic [2:0] T1     = 3'd1;
   localparam logic [2:0] T2     = 3'd2;
   localparam logic [2:0] T3     = 3'd3;
   localparam logic [2:0] T4     = 3'd4;
   localparam logic [2:0] T5     = 3'd5;
   localparam logic [2:0] T6     = 3'd6;
   localparam logic [2:0] TBLANK = 3'd7;

   localparam logic WHITE = 1'b0;
   localparam logic RED   = 1'b1;

   localparam int unsigned NumTypes = 6;

   typedef enum logic [1:0] {
      SideN = 2'd0,
      SideE = 2'd1,
      SideS = 2'd2,
      SideW = 2'd3
   } side_e;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StChkUp    = 3'd1,
      StChkRight = 3'd2,
      StChkDown  = 3'd3,
      StChkLeft  = 3'd4,
      StDone     = 3'd5
   } state_e;

   // Rows packed as {N, E, S, W}; red = 1.
   function automatic logic edge_colour(input logic [2:0] tile, input side_e side);
      logic [3:0] row;
      case (tile)
         T1:      row = {WHITE, RED,   WHITE, RED  };
         T2:      row = {RED,   WHITE, RED,   WHITE};
         T3:      row = {WHITE, WHITE, RED,   RED  };
         T4:      row = {RED,   WHITE, WHITE, RED  };
         T5:      row = {RED,   RED,   WHITE, WHITE};
         T6:      row = {WHITE, RED,   RED,   WHITE};
         default: row = 4'b0000;
      endcase
      case (side)
         SideN:   edge_colour = row[3];
         SideE:   edge_colour = row[2];
         SideS:   edge_colour = row[1];
         default: edge_colour = row[0];
      endcase
   endfunction

   function automatic side_e opposite(input side_e side);
      opposite = side_e'(side + 2'd2);
   endfunction

   function automatic logic is_empty(input logic [2:0] tile);
      is_empty = (tile == EMPTY) || (tile == TBLANK);
   endfunction

endpackage

// File: rtl/tile_edge_mask.sv
// Combinational legality mask for one neighbour: bit k set when tile type k+1 placed in the
// target cell shows the same colour on side_i as the neighbour shows on the facing side.
module tile_edge_mask
   import trax_pkg::*;
(
   input  logic [2:0] nb_type_i,
   input  side_e      side_i,
   output logic [5:0] mask_o
);

   logic nb_colour;

   always_comb begin
      nb_colour = edge_colour(nb_type_i, opposite(side_i));
      mask_o    = '1;
      if (!is_empty(nb_type_i)) begin
         for (int k = 0; k < NumTypes; k++) begin
            mask_o[k] = (edge_colour(3'(k + 1), side_i) == nb_colour);
         end
      end
   end

endmodule

// File: rtl/tile_check.sv
// Trax placement checker: latches the four neighbours on a start rise, narrows a 6-type
// legality mask one neighbour per clock, then presents the mask with endsignal.
module tile_check
   import trax_pkg::*;
(
   output logic [5:0] tile_type,
   output logic       endsignal,
   input  logic       start_signal,
   input  logic [2:0] up_tile,
   input  logic [2:0] down_tile,
   input  logic [2:0] right_tile,
   input  logic [2:0] left_tile,
   input  logic       clk,
   input  logic       rst_n
);

   state_e     state_q, state_d;
   logic       start_q;
   logic [2:0] up_q, up_d;
   logic [2:0] down_q, down_d;
   logic [2:0] right_q, right_d;
   logic [2:0] left_q, left_d;
   logic [5:0] mask_q, mask_d;
   logic [5:0] tile_type_q, tile_type_d;
   logic       end_q, end_d;

   logic [2:0] nb_sel;
   side_e      side_sel;
   logic [5:0] nb_mask;
   logic       start_rise;
   logic       busy;

   // One shared mask unit; the FSM state picks which latched neighbour it sees.
   always_comb begin
      nb_sel   = EMPTY;
      side_sel = SideN;
      unique case (state_q)
         StChkUp: begin
            nb_sel   = up_q;
            side_sel = SideN;
         end
         StChkRight: begin
            nb_sel   = right_q;
            side_sel = SideE;
         end
         StChkDown: begin
            nb_sel   = down_q;
            side_sel = SideS;
         end
         StChkLeft: begin
            nb_sel   = left_q;
            side_sel = SideW;
         end
         default: begin
            nb_sel   = EMPTY;
            side_sel = SideN;
         end
      endcase
   end

   tile_edge_mask u_edge_mask (
      .nb_type_i (nb_sel),
      .side_i    (side_sel),
      .mask_o    (nb_mask)
   );

   assign start_rise = start_signal & ~start_q;
   assign busy       = (state_q == StChkUp)   || (state_q == StChkRight) ||
                       (state_q == StChkDown) || (state_q == StChkLeft);

   always_comb begin
      state_d     = state_q;
      up_d        = up_q;
      down_d      = down_q;
      right_d     = right_q;
      left_d      = left_q;
      mask_d      = mask_q;
      tile_type_d = tile_type_q;
      end_d       = end_q;

      unique case (state_q)
         StIdle: begin
            end_d = 1'b0;
         end
         StChkUp: begin
            mask_d  = mask_q & nb_mask;
            state_d = StChkRight;
         end
         StChkRight: begin
            mask_d  = mask_q & nb_mask;
            state_d = StChkDown;
         end
         StChkDown: begin
            mask_d  = mask_q & nb_mask;
            state_d = StChkLeft;
         end
         StChkLeft: begin
            mask_d  = mask_q & nb_mask;
            state_d = StDone;
         end
         StDone: begin
            tile_type_d = mask_q;
            end_d       = 1'b1;
            // Result is shown for at least one cycle before start low releases it.
            if (end_q && !start_signal) begin
               state_d = StIdle;
               end_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            end_d   = 1'b0;
         end
      endcase

      if (start_rise && !busy) begin
         up_d    = up_tile;
         down_d  = down_tile;
         right_d = right_tile;
         left_d  = left_tile;
         mask_d  = 6'b111111;
         end_d   = 1'b0;
         state_d = StChkUp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         start_q     <= 1'b0;
         up_q        <= EMPTY;
         down_q      <= EMPTY;
         right_q     <= EMPTY;
         left_q      <= EMPTY;
         mask_q      <= '0;
         tile_type_q <= '0;
         end_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_signal;
         up_q        <= up_d;
         down_q      <= down_d;
         right_q     <= right_d;
         left_q      <= left_d;
         mask_q      <= mask_d;
         tile_type_q <= tile_type_d;
         end_q       <= end_d;
      end
   end

   assign tile_type = tile_type_q;
   assign endsignal = end_q;

endmodule

// File: tb/tb_tile_check.sv
// Directed bench for tile_check: hand-computed legality masks, latency, restart,
// mid-check input/start changes and asynchronous reset.
module tb_tile_check;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_signal = 1'b0;
   logic [2:0] up_tile = 3'd0;
   logic [2:0] down_tile = 3'd0;
   logic [2:0] right_tile = 3'd0;
   logic [2:0] left_tile = 3'd0;
   logic [5:0] tile_type;
   logic       endsignal;

   int n_checks = 0;
   int n_fails  = 0;

   tile_check dut (
      .tile_type    (tile_type),
      .endsignal    (endsignal),
      .start_signal (start_signal),
      .up_tile      (up_tile),
      .down_tile    (down_tile),
      .right_tile   (right_tile),
      .left_tile    (left_tile),
      .clk          (clk),
      .rst_n        (rst_n)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Return to idle, present neighbours, raise start, and check latency plus final mask.
   task automatic run(input string tag, input logic [2:0] u, input logic [2:0] d,
                      input logic [2:0] r, input logic [2:0] l, input logic [5:0] exp);
      start_signal = 1'b0;
      tick();
      tick();
      up_tile      = u;
      down_tile    = d;
      right_tile   = r;
      left_tile    = l;
      start_signal = 1'b1;
      tick();
      repeat (4) tick();
      check({tag, "_not_early"}, {5'd0, endsignal}, 6'd0);
      tick();
      check({tag, "_end"}, {5'd0, endsignal}, 6'd1);
      check({tag, "_mask"}, tile_type, exp);
   endtask

   initial begin
      #12;
      check("reset_mask", tile_type, 6'b000000);
      check("reset_end", {5'd0, endsignal}, 6'd0);
      rst_n = 1'b1;
      tick();

      run("t1_up1", 3'd1, 3'd0, 3'd0, 3'd0, 6'b100101);

      tick();
      check("t1_hold_end", {5'd0, endsignal}, 6'd1);
      start_signal = 1'b0;
      tick();
      check("t2_drop_end", {5'd0, endsignal}, 6'd0);
      check("t2_keep_mask", tile_type, 6'b100101);

      run("t2_up1_dn2", 3'd1, 3'd2, 3'd0, 3'd0, 6'b100100);
      run("t3_l3_r6", 3'd0, 3'd0, 3'd6, 3'd3, 6'b000010);
      run("t4_empty", 3'd0, 3'd0, 3'd0, 3'd0, 6'b111111);
      run("t4_conflict", 3'd1, 3'd1, 3'd5, 3'd3, 6'b000000);
      run("t4_code7", 3'd7, 3'd0, 3'd2, 3'd7, 6'b001110);
      run("t4_up6", 3'd6, 3'd0, 3'd0, 3'd0, 6'b011010);

      // Inputs and start disturbed mid-check: result follows the latched up=1 case.
      start_signal = 1'b0;
      tick();
      tick();
      up_tile      = 3'd1;
      down_tile    = 3'd0;
      right_tile   = 3'd0;
      left_tile    = 3'd0;
      start_signal = 1'b1;
      tick();
      tick();
      up_tile      = 3'd2;
      down_tile    = 3'd2;
      right_tile   = 3'd6;
      left_tile    = 3'd3;
      start_signal = 1'b0;
      tick();
      start_signal = 1'b1;
      tick();
      tick();
      check("t5_not_early", {5'd0, endsignal}, 6'd0);
      tick();
      check("t5_no_restart_end", {5'd0, endsignal}, 6'd1);
      check("t5_latched_mask", tile_type, 6'b100101);

      // Asynchronous reset in the middle of a check.
      start_signal = 1'b0;
      tick();
      tick();
      up_tile      = 3'd3;
      down_tile    = 3'd0;
      right_tile   = 3'd0;
      left_tile    = 3'd0;
      start_signal = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_mask", tile_type, 6'b000000);
      check("t6_async_end", {5'd0, endsignal}, 6'd0);
      start_signal = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("t6_idle_end", {5'd0, endsignal}, 6'd0);

      run("t6_after_reset", 3'd6, 3'd0, 3'd0, 3'd0, 6'b011010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
